// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction-fetch front end.
//   INSTR_W / ADDR_W   : instruction word and address widths
//   DEFAULT_RESET_PC   : default reset vector
//   fetch_state_e      : fetch sequencer states
// Build option: PC_MISALIGN_TRAP_EN adds the HALT state used by the
// misaligned-PC trap.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_HALT    = 3'd4
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } fetch_state_e;
`endif

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Architectural program-counter register.
//   clk, rst     : clock, synchronous active-high reset (loads RESET_PC)
//   load_en_i    : load next_pc_i on this edge
//   next_pc_i    : candidate next PC
//   pc_o         : current PC
//   pc_plus4_o   : pc_o + 4 (combinational, wraps modulo 2^32)
// MASK_LOW=1 forces bits [1:0] of the loaded value to zero so the PC can
// never become misaligned.
// -----------------------------------------------------------------------------
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter bit                MASK_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] next_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    generate
        if (MASK_LOW) begin : g_mask
            assign pc_d = {next_pc_i[ADDR_W-1:2], 2'b00};
        end else begin : g_nomask
            assign pc_d = next_pc_i;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load_en_i) begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// PC register and instruction-fetch sequencer: one fetch per instruction over
// a valid/ready request, one-beat response, then presents the word to decode.
//   clk, rst                       : clock, synchronous active-high reset
//   next_pc                        : next PC, sampled when decode accepts
//   imem_req_valid/ready, imem_addr: fetch request channel (addr = pc_out)
//   imem_rsp_valid, imem_rsp_data  : fetch response
//   instr_valid/ready, instr       : instruction to decode
//   pc_out, pc_plus4               : current PC and PC+4 (combinational)
//   retired_count                  : accepted-instruction count (wraps)
//   misalign_err                   : sticky misaligned-PC flag
// Build option: PC_MISALIGN_TRAP_EN. When defined, a misaligned next_pc on
// accept is not loaded, sets misalign_err and parks the unit in HALT until
// reset. When undefined, next_pc[1:0] is forced to zero and misalign_err is 0.
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  next_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic [31:0]        retired_count,
    output logic               misalign_err
);

    fetch_state_e state_q, state_d;

    logic               pc_load;
    logic               instr_load;
    logic               retire;
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        retired_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state / strobes ----------------
    always_comb begin
        state_d    = state_q;
        pc_load    = 1'b0;
        instr_load = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_RESET:   state_d = ST_FETCH;
            ST_FETCH:   if (imem_req_ready) state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_load = 1'b1;
                    state_d    = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (instr_ready) begin
                    retire = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                    // Misaligned target: keep the old PC and park.
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end
`else
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            ST_HALT:    state_d = ST_HALT;
`endif
            default:    state_d = ST_RESET;
        endcase
    end

    // ---------------- PC register ----------------
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit PC_MASK_LOW = 1'b0;
`else
    localparam bit PC_MASK_LOW = 1'b1;
`endif

    pc_reg #(
        .RESET_PC (RESET_PC),
        .MASK_LOW (PC_MASK_LOW)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .load_en_i  (pc_load),
        .next_pc_i  (next_pc),
        .pc_o       (pc_out),
        .pc_plus4_o (pc_plus4)
    );

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            if (instr_load) instr_q <= imem_rsp_data;
            if (retire)     retired_q <= retired_q + 32'd1;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (state_q == ST_DELIVER && instr_ready && next_pc[1:0] != 2'b00) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    // ---------------- outputs ----------------
    assign imem_req_valid = (state_q == ST_FETCH);
    assign instr_valid    = (state_q == ST_DELIVER);
    assign imem_addr      = pc_out;
    assign instr          = instr_q;
    assign retired_count  = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit. Expected fetch addresses and instruction
// words go into queues when the stimulus is driven and are popped when the
// DUT presents the matching request or instruction.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] retired_count;
    logic        misalign_err;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int last_accept_cyc = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_retired;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .retired_count  (retired_count),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic pop_addr(output logic [31:0] v);
        if (exp_addr_q.size() == 0) begin
            check("addr_q_empty", 32'd0, 32'd1);
            v = 32'hDEAD_BEEF;
        end else begin
            v = exp_addr_q.pop_front();
        end
    endtask

    task automatic pop_instr(output logic [31:0] v);
        if (exp_instr_q.size() == 0) begin
            check("instr_q_empty", 32'd0, 32'd1);
            v = 32'hDEAD_BEEF;
        end else begin
            v = exp_instr_q.pop_front();
        end
    endtask

    // Wait (bounded) for a fetch request; sampling is on the falling edge.
    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", {31'd0, imem_req_valid}, 32'd1);
    endtask

    // One full instruction: optional FETCH stall, response delay and DELIVER
    // hold, then accept with npc. gap>0 checks cycles between accepts.
    task automatic run_instr(input int req_hold, input int rsp_delay, input int dly_hold,
                             input logic [31:0] npc, input int gap);
        logic [31:0] a, w, a_next;
        wait_req();
        pop_addr(a);
        check("imem_addr", imem_addr, a);
        check("pc_plus4", pc_plus4, a + 32'd4);
        for (int i = 0; i < req_hold; i++) begin
            imem_req_ready = 1'b0;
            instr_ready    = 1'b1;          // ignored outside DELIVER
            @(negedge clk);
            instr_ready    = 1'b0;
            check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("stall_addr", imem_addr, a);
            check("stall_retired", retired_count, exp_retired);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 0; i < rsp_delay; i++) begin
            @(negedge clk);
            check("wait_instr_vld", {31'd0, instr_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(a);
        exp_instr_q.push_back(mem_word(a));
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("instr_valid", {31'd0, instr_valid}, 32'd1);
        pop_instr(w);
        check("instr", instr, w);
        for (int i = 0; i < dly_hold; i++) begin
            instr_ready    = 1'b0;
            next_pc        = $urandom;      // must not be loaded
            imem_rsp_valid = (i == 0);      // stray response, must be ignored
            imem_rsp_data  = 32'hBAD0_0000 | i;
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            check("hold_instr_vld", {31'd0, instr_valid}, 32'd1);
            check("hold_instr", instr, w);
            check("hold_pc", pc_out, a);
        end
        instr_ready = 1'b1;
        next_pc     = npc;
`ifdef PC_MISALIGN_TRAP_EN
        a_next = (npc[1:0] == 2'b00) ? npc : a;
        if (npc[1:0] == 2'b00) exp_addr_q.push_back(npc);
`else
        a_next = {npc[31:2], 2'b00};
        exp_addr_q.push_back(a_next);
`endif
        exp_retired = exp_retired + 32'd1;
        @(negedge clk);
        instr_ready = 1'b0;
        next_pc     = 32'h0;
        check("retired_count", retired_count, exp_retired);
        check("pc_after_accept", pc_out, a_next);
        if (gap > 0) check("accept_gap", cyc - last_accept_cyc, gap);
        last_accept_cyc = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_retired", retired_count, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0;
        exp_retired = 32'd0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        exp_addr_q.push_back(32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        next_pc        = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        exp_retired    = 32'd0;

        do_reset();
        check("rst_pc_plus4", pc_plus4, 32'd4);

        // Sequential zero-wait stream: 3 cycles per instruction.
        run_instr(0, 0, 0, 32'h0000_0004, 0);
        run_instr(0, 0, 0, 32'h0000_0008, 3);
        run_instr(0, 0, 0, 32'h0000_000C, 3);
        check("retired_three", retired_count, 32'd3);

        // Memory not ready for 4 cycles.
        run_instr(4, 0, 0, 32'h0000_0010, 0);
        // Late response and decode hold with next_pc churn, then a jump.
        run_instr(0, 2, 5, 32'h0040_0100, 0);
        // Jump to the top of the address space; pc_plus4 wraps there.
        run_instr(0, 0, 0, 32'hFFFF_FFFC, 0);
        run_instr(0, 0, 0, 32'h0000_0006, 0);

`ifdef PC_MISALIGN_TRAP_EN
        check("misalign_err", {31'd0, misalign_err}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("halt_instr_vld", {31'd0, instr_valid}, 32'd0);
        end
        do_reset();
`else
        check("misalign_zero", {31'd0, misalign_err}, 32'd0);
        check("masked_addr", imem_addr, 32'h0000_0004);
        run_instr(0, 0, 0, 32'h0000_0008, 3);
`endif

        // Reset while waiting for a response; the late response is dropped.
        wait_req();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("wrst_instr_vld", {31'd0, instr_valid}, 32'd0);
        check("wrst_instr", instr, 32'd0);
        check("wrst_pc", pc_out, 32'd0);
        check("wrst_retired", retired_count, 32'd0);
        exp_retired = 32'd0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        exp_addr_q.push_back(32'd0);
        run_instr(0, 0, 0, 32'h0000_0004, 0);
        run_instr(0, 0, 0, 32'h0000_0008, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
